// File: rtl/seq_counter_pkg.sv
// seq_counter shared types and default sizes.
// Optional feature macro: SEQ_COUNTER_SAT_EN (saturate instead of wrap).
package seq_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STEP_W = 4;

endpackage

// File: rtl/seq_counter_step_unit.sv
// Combinational up/down step of WIDTH+1 bits with carry/borrow out.
// SEQ_COUNTER_SAT_EN: carrying free-run steps clamp instead of wrapping.
module seq_step_unit #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_val,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_dir,
  output logic [WIDTH-1:0]  o_nxt,
  output logic [WIDTH-1:0]  o_term,
  output logic              o_carry
);

  logic [WIDTH:0] w_ext;
  logic [WIDTH:0] w_sum;

  assign w_ext = {{(WIDTH+1-STEP_W){1'b0}}, i_step};

  // Extra top bit captures carry on add and borrow on subtract.
  assign w_sum = i_dir ? ({1'b0, i_val} - w_ext)
                       : ({1'b0, i_val} + w_ext);

  assign o_carry = w_sum[WIDTH];

  // Clamp value at the end of the range being counted toward.
  assign o_term = i_dir ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

`ifdef SEQ_COUNTER_SAT_EN
  assign o_nxt = o_carry ? o_term : w_sum[WIDTH-1:0];
`else
  assign o_nxt = w_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/seq_counter.sv
// Loadable programmable-step up/down counter with run-control FSM.
// Optional SEQ_COUNTER_SAT_EN saturates free-run carries (see step unit).
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic [WIDTH-1:0]  d,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              oneshot,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              ovf,
  output logic              busy,
  output logic              done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_term;
  logic             w_carry;

  seq_step_unit #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .i_val   (r_out),
    .i_step  (step),
    .i_dir   (dir),
    .o_nxt   (w_nxt),
    .o_term  (w_term),
    .o_carry (w_carry)
  );

  // Run-control FSM, load mux and counter register; reset > load > count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (select) begin
      r_out <= d;
      r_ovf <= 1'b0;
      r_tc  <= 1'b0;
      if (r_state == DONE)
        r_state <= en ? RUN : IDLE;
    end else begin
      r_tc <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en)
            r_state <= RUN;
        end
        RUN: begin
          if (!en) begin
            r_state <= IDLE;
          end else if (w_carry) begin
            r_tc <= 1'b1;
            if (oneshot) begin
              r_out   <= w_term;
              r_state <= DONE;
            end else begin
              r_out <= w_nxt;
              r_ovf <= 1'b1;
            end
          end else begin
            r_out <= w_nxt;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign ovf  = r_ovf;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter with an expected-value scoreboard.
// Build with SEQ_COUNTER_SAT_EN to check the saturating variant.
module tb_seq_counter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          select;
  logic [W-1:0]  d;
  logic          en;
  logic          dir;
  logic [SW-1:0] step;
  logic          oneshot;
  logic [W-1:0]  out;
  logic          tc;
  logic          ovf;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [W+3:0] exp_q[$];
  string        tag_q[$];

  always #5 clk = ~clk;

  seq_counter #(
    .WIDTH  (W),
    .STEP_W (SW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .select  (select),
    .d       (d),
    .en      (en),
    .dir     (dir),
    .step    (step),
    .oneshot (oneshot),
    .out     (out),
    .tc      (tc),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick(
    input logic [W-1:0] e_out,
    input logic         e_tc,
    input logic         e_ovf,
    input logic         e_busy,
    input logic         e_done,
    input string        tag
  );
    logic [W+3:0] obs;
    logic [W+3:0] expv;
    string        t;
    exp_q.push_back({e_out, e_tc, e_ovf, e_busy, e_done});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    expv = exp_q.pop_front();
    t    = tag_q.pop_front();
    obs  = {out, tc, ovf, busy, done};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed out=%h tc/ovf/busy/done=%b expected out=%h tc/ovf/busy/done=%b",
             t, obs[W+3:4], obs[3:0], expv[W+3:4], expv[3:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; select = 1'b0; d = '0; en = 1'b0;
    dir = 1'b0; step = '0; oneshot = 1'b0;
    @(posedge clk);
    #1;
    tick(16'h0000, 0, 0, 0, 0, "reset1");
    tick(16'h0000, 0, 0, 0, 0, "reset2");

    // start: transition edge does not step
    reset = 1'b0; en = 1'b1; step = 4'd1;
    tick(16'h0000, 0, 0, 1, 0, "go");
    for (int i = 1; i <= 9; i++)
      tick(W'(i), 0, 0, 1, 0, "count_up");

    // mid-run load held 3 edges
    select = 1'b1; d = 16'hBEEF;
    tick(16'hBEEF, 0, 0, 1, 0, "load1");
    tick(16'hBEEF, 0, 0, 1, 0, "load2");
    tick(16'hBEEF, 0, 0, 1, 0, "load3");
    select = 1'b0;
    tick(16'hBEF0, 0, 0, 1, 0, "resume1");
    tick(16'hBEF1, 0, 0, 1, 0, "resume2");

    // up wrap
    select = 1'b1; d = 16'hFFFE;
    tick(16'hFFFE, 0, 0, 1, 0, "ld_fffe");
    select = 1'b0;
    tick(16'hFFFF, 0, 0, 1, 0, "up_ffff");
`ifdef SEQ_COUNTER_SAT_EN
    tick(16'hFFFF, 1, 1, 1, 0, "up_sat");
    tick(16'hFFFF, 1, 1, 1, 0, "up_sat2");
`else
    tick(16'h0000, 1, 1, 1, 0, "up_wrap");
    tick(16'h0001, 0, 1, 1, 0, "ovf_sticky");
`endif

    // down wrap, load clears ovf
    select = 1'b1; d = 16'h0003;
    tick(16'h0003, 0, 0, 1, 0, "ld_0003");
    select = 1'b0; dir = 1'b1; step = 4'd2;
    tick(16'h0001, 0, 0, 1, 0, "dn_0001");
`ifdef SEQ_COUNTER_SAT_EN
    tick(16'h0000, 1, 1, 1, 0, "dn_sat");
    en = 1'b0;
    tick(16'h0000, 0, 1, 0, 0, "en_drop");
    tick(16'h0000, 0, 1, 0, 0, "idle_frozen");
`else
    tick(16'hFFFF, 1, 1, 1, 0, "dn_wrap");
    en = 1'b0;
    tick(16'hFFFF, 0, 1, 0, 0, "en_drop");
    tick(16'hFFFF, 0, 1, 0, 0, "idle_frozen");
`endif

    // one-shot up; load in IDLE keeps IDLE
    select = 1'b1; d = 16'hFFFD; en = 1'b1;
    dir = 1'b0; step = 4'd2; oneshot = 1'b1;
    tick(16'hFFFD, 0, 0, 0, 0, "ld_idle");
    select = 1'b0;
    tick(16'hFFFD, 0, 0, 1, 0, "os_go");
    tick(16'hFFFF, 0, 0, 1, 0, "os_ffff");
    tick(16'hFFFF, 1, 0, 0, 1, "os_done");
    tick(16'hFFFF, 0, 0, 0, 1, "done_hold1");
    tick(16'hFFFF, 0, 0, 0, 1, "done_hold2");

    // load from DONE with en=1 restarts
    select = 1'b1; d = 16'h0010;
    tick(16'h0010, 0, 0, 1, 0, "ld_done");
    select = 1'b0;
    tick(16'h0012, 0, 0, 1, 0, "restart");

    // zero step holds value
    step = 4'd0;
    tick(16'h0012, 0, 0, 1, 0, "step0_a");
    tick(16'h0012, 0, 0, 1, 0, "step0_b");

    // reach DONE again, then reset in DONE
    step = 4'd2; select = 1'b1; d = 16'hFFFF;
    tick(16'hFFFF, 0, 0, 1, 0, "ld_ffff");
    select = 1'b0;
    tick(16'hFFFF, 1, 0, 0, 1, "os_done2");
    reset = 1'b1;
    tick(16'h0000, 0, 0, 0, 0, "rst_done");

    // one-shot down clamps to zero
    reset = 1'b0; select = 1'b1; d = 16'h0002;
    dir = 1'b1; step = 4'd3;
    tick(16'h0002, 0, 0, 0, 0, "ld_0002");
    select = 1'b0;
    tick(16'h0002, 0, 0, 1, 0, "osd_go");
    tick(16'h0000, 1, 0, 0, 1, "osd_done");

    // reset mid-run
    select = 1'b1; d = 16'h0100; oneshot = 1'b0; dir = 1'b0;
    tick(16'h0100, 0, 0, 1, 0, "ld_0100");
    select = 1'b0;
    tick(16'h0103, 0, 0, 1, 0, "run_0103");
    reset = 1'b1;
    tick(16'h0000, 0, 0, 0, 0, "rst_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_counter.md
Name: seq_counter

Overview:
- Parametrised successor to the 16-bit load-mux/increment block.
- Combines a loadable register (select/d mux) with a programmable-step up/down counter, free-running or one-shot.
- Adds wrap detection, a sticky overflow flag and a small run-control FSM.
- Sits as a generic timing/address counter, driven by a controller or a bench.

Parameters:
- WIDTH, 16, counter/data width in bits (>=2).
- STEP_W, 4, width of the step input (STEP_W <= WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- select  in  1  load strobe; when 1, out <= d.
- d  in  WIDTH  load value.
- en  in  1  run enable (level).
- dir  in  1  0 = count up, 1 = count down.
- step  in  STEP_W  unsigned increment per counting cycle.
- oneshot  in  1  0 = free-run (wrap), 1 = stop at terminal.
- out  out  WIDTH  counter value.
- tc  out  1  terminal pulse: 1 in the cycle after an attempted step carried/borrowed.
- ovf  out  1  sticky wrap flag.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset (sampled at posedge): out = 0, state = IDLE, tc = 0, ovf = 0, so busy = 0 and done = 0.
- Priority per edge: reset > select > counting.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when en = 1. The transition cycle does not step.
  - RUN -> IDLE when en = 0.
  - RUN -> DONE on carry/borrow with oneshot = 1.
  - DONE holds until select or reset.
- Counting (state RUN, en = 1, select = 0):
  - nxt = {1'b0, out} + step when dir = 0; nxt = {1'b0, out} - step when dir = 1. Computed in WIDTH+1 bits, step zero-extended.
  - carry = nxt[WIDTH].
  - No carry: out <= nxt[WIDTH-1:0].
  - Carry, oneshot = 0: out <= nxt[WIDTH-1:0] (modulo 2^WIDTH), ovf <= 1, tc = 1.
  - Carry, oneshot = 1: out <= all-ones (up) or 0 (down), state <= DONE, tc = 1, ovf unchanged.
  - step = 0: out unchanged, no tc.
- Load (select = 1): out <= d, ovf <= 0, no step that cycle.
  - In IDLE/RUN the state is kept.
  - In DONE: next state is RUN if en = 1, else IDLE.
  - Load held for several cycles: out stays d; counting resumes on the first edge with select = 0.
- tc is registered, high for exactly one cycle per carry event. Consecutive carrying steps give consecutive tc highs.
- Latency: en rising to first change of out is 2 edges (transition, then step).
- Reset mid-RUN or in DONE aborts to the reset values on that edge.
- dir, step and oneshot may change on any cycle; they take effect on the next counting edge.

Optional Feature:
- Macro SEQ_COUNTER_SAT_EN.
- Defined: in free-run (oneshot = 0) a carry saturates out to all-ones (up) or 0 (down) instead of wrapping. tc and ovf behave as in wrap mode, and state stays RUN.
- Undefined: modulo wrap as described above.
- One-shot behaviour is identical either way.

Decomposition:
- Package seq_counter_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}.
  - Constants DEF_WIDTH = 16, DEF_STEP_W = 4.
- Sub-module seq_step_unit: combinational add/sub of WIDTH+1 bits, outputs nxt and carry, with saturation logic under SEQ_COUNTER_SAT_EN.
- seq_counter holds the FSM, registers and load mux.

Test Plan:
- Reset: reset = 1 for 2 edges -> out = 0x0000, tc = ovf = busy = done = 0. Then en = 1, step = 1, dir = 0 for 10 edges -> busy = 1, out = 0x0009.
- Mid-run load: while running at 0x0009, select = 1 with d = 0xBEEF for 3 edges -> out = 0xBEEF held; after select = 0, out = 0xBEF0, 0xBEF1.
- Up wrap: load 0xFFFE, step = 1, oneshot = 0, run -> out 0xFFFF, then 0x0000 with tc pulse; ovf = 1 remains after tc drops. With SEQ_COUNTER_SAT_EN: 0xFFFF, 0xFFFF, tc each carrying cycle.
- Down wrap: load 0x0003, dir = 1, step = 2 -> 0x0001, then 0xFFFF with tc and ovf = 1 (0x0000 with SEQ_COUNTER_SAT_EN).
- One-shot: load 0xFFFD, step = 2, oneshot = 1 -> 0xFFFF, then out = 0xFFFF, done = 1, tc one cycle; en held high keeps DONE. select with d = 0x0010 -> RUN, out 0x0010, then 0x0012.
- Reset mid-operation and en drop: reset = 1 while in DONE -> all outputs at reset values next edge. en = 0 during RUN -> IDLE, out frozen; step = 0 in RUN -> out constant, no tc.
